// File: rtl/hamming_pkg.sv
// Shared definitions for the Hamming frame transmit scheduler: word/frame
// geometry, frame delimiter and the scheduler state encoding.
package hamming_pkg;

    localparam int WORD_W = 32;
    localparam int FRAME_W = 64;
    localparam logic [7:0] FRAME_HEADER = 8'b01111110;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_LOAD      = 2'd1,
        S_WAIT_BUSY = 2'd2,
        S_WAIT_DONE = 2'd3
    } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: the first requesting index found searching
// upward from last_grant+1, wrapping, so the previous winner is served last.
module rr_arbiter #(
    parameter int N_REQ = 4,
    localparam int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] last_grant,
    output logic [N_REQ-1:0] grant,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    int cand;

    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        cand  = 0;
        for (int i = 1; i <= N_REQ; i++) begin
            cand = (int'(last_grant) + i) % N_REQ;
            if (!any && req[cand[IDX_W-1:0]]) begin
                any = 1'b1;
                idx = cand[IDX_W-1:0];
                grant[cand[IDX_W-1:0]] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/hamming_tx_scheduler.sv
// Shares one Hamming frame encoder between N_REQ word sources: round-robin
// accept, one-cycle start pulse, then wait for completion or time out.
module hamming_tx_scheduler
    import hamming_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int TIMEOUT = 256,
    localparam int IDX_W  = $clog2(N_REQ)
) (
    input  logic                    clk_in,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [N_REQ*WORD_W-1:0] req_data,
    output logic [N_REQ-1:0]        req_ready,
    output logic [WORD_W-1:0]       enc_data,
    output logic                    enc_start,
    input  logic                    enc_busy,
    input  logic                    enc_done,
    output logic [IDX_W-1:0]        grant_id,
    output logic                    busy,
    output logic                    timeout_err,
    output logic [15:0]             frame_count,
    output state_t                  fsm_state
);

    localparam int CNT_W = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t            state;
    state_t            state_next;
    logic [IDX_W-1:0]  last_grant;
    logic [N_REQ-1:0]  arb_grant;
    logic [IDX_W-1:0]  arb_idx;
    logic              arb_any;
    logic [WORD_W-1:0] winner_word;
    logic [CNT_W-1:0]  cnt;
    logic              transfer;
    logic              frame_done;

    rr_arbiter #(.N_REQ(N_REQ)) u_arb (
        .req        (req_valid),
        .last_grant (last_grant),
        .grant      (arb_grant),
        .idx        (arb_idx),
        .any        (arb_any)
    );

    always_comb begin
        winner_word = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (arb_idx == IDX_W'(i)) winner_word = req_data[i*WORD_W +: WORD_W];
        end
    end

    // Handshake: a word moves when req_valid[i] and req_ready[i] are both high
    // at a rising edge; ready is only ever offered to the arbitration winner,
    // only in IDLE with the encoder idle, and never waits on anything else.
    always_comb begin
        state_next  = state;
        req_ready   = '0;
        enc_start   = 1'b0;
        timeout_err = 1'b0;
        frame_done  = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (!enc_busy && arb_any) begin
                    req_ready  = arb_grant;
                    state_next = S_LOAD;
                end
            end
            S_LOAD: begin
                enc_start  = 1'b1;
                state_next = S_WAIT_BUSY;
            end
            S_WAIT_BUSY, S_WAIT_DONE: begin
                // Completion beats the timeout when both land on the same cycle.
                if (enc_done) begin
                    frame_done = 1'b1;
                    state_next = S_IDLE;
                end else if (cnt == CNT_LAST) begin
                    timeout_err = 1'b1;
                    state_next  = S_IDLE;
                end else if (state == S_WAIT_BUSY && enc_busy) begin
                    state_next = S_WAIT_DONE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    assign transfer  = |(req_valid & req_ready);
    assign busy      = (state != S_IDLE);
    assign fsm_state = state;

    always_ff @(posedge clk_in) begin
        if (rst) begin
            state       <= S_IDLE;
            enc_data    <= '0;
            grant_id    <= '0;
            last_grant  <= IDX_W'(N_REQ - 1);
            cnt         <= '0;
            frame_count <= '0;
        end else begin
            state <= state_next;
            if (transfer) begin
                enc_data   <= winner_word;
                grant_id   <= arb_idx;
                last_grant <= arb_idx;
            end
            if (state == S_LOAD) begin
                cnt <= '0;
            end else if (state == S_WAIT_BUSY || state == S_WAIT_DONE) begin
                cnt <= cnt + 1'b1;
            end
            if (frame_done) begin
                frame_count <= frame_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_hamming_tx_scheduler.sv
// Bench for hamming_tx_scheduler: behavioural model checked every cycle, plus
// directed scenarios with hand-computed literal expectations.
module tb_hamming_tx_scheduler;
    import hamming_pkg::*;

    localparam int N  = 4;
    localparam int TO = 256;

    // clock / reset
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst = 1'b1;
    logic [N-1:0]    req_valid = '0;
    logic [N*32-1:0] req_data = '0;
    logic [N-1:0]    req_ready;
    logic [31:0]     enc_data;
    logic            enc_start;
    logic            enc_busy = 1'b0;
    logic            enc_done = 1'b0;
    logic [1:0]      grant_id;
    logic            busy;
    logic            timeout_err;
    logic [15:0]     frame_count;
    state_t          fsm_state;

    hamming_tx_scheduler #(.N_REQ(N), .TIMEOUT(TO)) dut (
        .clk_in      (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .enc_data    (enc_data),
        .enc_start   (enc_start),
        .enc_busy    (enc_busy),
        .enc_done    (enc_done),
        .grant_id    (grant_id),
        .busy        (busy),
        .timeout_err (timeout_err),
        .frame_count (frame_count),
        .fsm_state   (fsm_state)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int n_to  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: event never seen within its cycle budget at %0t", name, $time);
    endtask

    // behavioural model: frame age counts cycles since the start pulse
    logic        model_on = 1'b0;
    logic        m_idle = 1'b1;
    int          m_age = 0;
    int          m_last = N - 1;
    logic [15:0] m_count = '0;
    logic [31:0] m_data = '0;
    int          m_gid = 0;
    int          m_pick;
    logic [31:0] exp_q[$];

    function automatic int pick(input logic [N-1:0] v, input int last);
        for (int i = 1; i <= N; i++) begin
            if (v[(last + i) % N]) return (last + i) % N;
        end
        return -1;
    endfunction

    always_comb m_pick = pick(req_valid, m_last);

    always @(posedge clk) begin
        if (rst) begin
            model_on <= 1'b1;
            m_idle   <= 1'b1;
            m_age    <= 0;
            m_last   <= N - 1;
            m_count  <= '0;
            m_data   <= '0;
            m_gid    <= 0;
            exp_q.delete();
        end else if (m_idle) begin
            if (!enc_busy && m_pick >= 0) begin
                m_data <= req_data[m_pick*32 +: 32];
                m_gid  <= m_pick;
                m_last <= m_pick;
                m_idle <= 1'b0;
                m_age  <= 0;
                exp_q.push_back(req_data[m_pick*32 +: 32]);
            end
        end else if (m_age == 0) begin
            m_age <= 1;
        end else if (enc_done) begin
            m_count <= m_count + 16'd1;
            m_idle  <= 1'b1;
        end else if (m_age == TO) begin
            m_idle <= 1'b1;
        end else begin
            m_age <= m_age + 1;
        end
    end

    // scoreboard / compare process
    always @(negedge clk) begin
        if (model_on) begin
            check("req_ready", 32'(req_ready),
                  (m_idle && !enc_busy && m_pick >= 0) ? (32'd1 << m_pick) : 32'd0);
            check("enc_start", 32'(enc_start), 32'(!m_idle && m_age == 0));
            check("busy", 32'(busy), 32'(!m_idle));
            check("state_idle", 32'(fsm_state == S_IDLE), 32'(m_idle));
            check("timeout_err", 32'(timeout_err), 32'(!m_idle && m_age == TO && !enc_done));
            check("enc_data", enc_data, m_data);
            check("grant_id", 32'(grant_id), 32'(m_gid));
            check("frame_count", 32'(frame_count), 32'(m_count));
            if (timeout_err === 1'b1) n_to++;
            if (enc_start === 1'b1) begin
                if (exp_q.size() == 0) fail_now("sb_word_queue");
                else check("sb_word", enc_data, exp_q.pop_front());
            end
        end
    end

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_start(output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (enc_start === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) fail_now("enc_start_wait");
    endtask

    // Wait for the start pulse, model an encoder finishing d cycles later.
    task automatic serve(input int d, input bit use_busy, input logic [N-1:0] v_after,
                         output int gid);
        bit ok;
        wait_start(ok);
        gid = int'(grant_id);
        tick();
        req_valid = v_after;
        enc_busy  = use_busy;
        repeat (d - 1) tick();
        enc_done = 1'b1;
        tick();
        enc_done = 1'b0;
        enc_busy = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: run did not complete, %0d compared / %0d mismatched", n_cmp, n_bad);
        $fatal(1, "watchdog expired");
    end

    int gid;
    int cyc;
    bit ok;
    int exp_seq[8] = '{0, 1, 2, 3, 0, 1, 2, 3};

    initial begin
        // reset values
        repeat (3) tick();
        @(negedge clk);
        check("rst_ready", 32'(req_ready), 32'd0);
        check("rst_enc_data", enc_data, 32'd0);
        check("rst_enc_start", 32'(enc_start), 32'd0);
        check("rst_grant", 32'(grant_id), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_timeout", 32'(timeout_err), 32'd0);
        check("rst_count", 32'(frame_count), 32'd0);
        tick();
        rst = 1'b0;

        // single requester, 64-cycle frame
        req_data[31:0] = 32'hDEADBEEF;
        req_valid = 4'b0001;
        @(negedge clk);
        check("t1_ready_same_cycle", 32'(req_ready), 32'h1);
        serve(64, 1'b1, 4'b0000, gid);
        check("t1_grant", 32'(gid), 32'd0);
        check("t1_enc_data", enc_data, 32'hDEADBEEF);
        @(negedge clk);
        check("t1_count", 32'(frame_count), 32'd1);
        check("t1_busy_low", 32'(busy), 32'd0);

        // fairness: all four continuously valid after a fresh reset
        tick();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        req_data = {32'hA3A3A3A3, 32'hA2A2A2A2, 32'hA1A1A1A1, 32'hA0A0A0A0};
        req_valid = 4'b1111;
        for (int f = 0; f < 8; f++) begin
            serve(64, 1'b1, (f == 7) ? 4'b0000 : 4'b1111, gid);
            check("t2_grant_seq", 32'(gid), 32'(exp_seq[f]));
        end
        @(negedge clk);
        check("t2_count", 32'(frame_count), 32'd8);

        // silent encoder: timeout exactly 256 cycles after enc_start
        tick();
        req_valid = 4'b0110;
        wait_start(ok);
        cyc = 0;
        for (int k = 1; k <= 400; k++) begin
            @(negedge clk);
            if (timeout_err === 1'b1) begin
                cyc = k;
                break;
            end
        end
        if (cyc == 0) fail_now("t3_timeout_wait");
        else check("t3_timeout_delay", 32'(cyc), 32'd256);
        @(negedge clk);
        check("t3_count_kept", 32'(frame_count), 32'd8);
        serve(64, 1'b1, 4'b0000, gid);
        check("t3_next_grant", 32'(gid), 32'd2);
        check("t3_count_after", 32'(frame_count), 32'd9);

        // enc_done coinciding with expiry, from both wait states
        req_valid = 4'b0001;
        serve(256, 1'b1, 4'b0000, gid);
        @(negedge clk);
        check("t4_done_at_expiry_busy", 32'(frame_count), 32'd10);
        tick();
        req_valid = 4'b0001;
        serve(256, 1'b0, 4'b0000, gid);
        @(negedge clk);
        check("t4_done_at_expiry_nobusy", 32'(frame_count), 32'd11);
        tick();
        req_valid = 4'b0001;
        serve(257, 1'b1, 4'b0000, gid);
        @(negedge clk);
        check("t4_done_after_expiry", 32'(frame_count), 32'd11);

        // spurious done in LOAD, then reset in WAIT_DONE
        tick();
        req_valid = 4'b0001;
        tick();
        enc_done  = 1'b1;
        req_valid = 4'b0000;
        tick();
        enc_done = 1'b0;
        @(negedge clk);
        check("t5_load_done_ignored", 32'(busy), 32'd1);
        check("t5_load_done_count", 32'(frame_count), 32'd11);
        tick();
        enc_busy = 1'b1;
        repeat (3) tick();
        rst = 1'b1;
        enc_busy = 1'b0;
        tick();
        @(negedge clk);
        check("t5_rst_busy", 32'(busy), 32'd0);
        check("t5_rst_count", 32'(frame_count), 32'd0);
        check("t5_rst_data", enc_data, 32'd0);
        check("t5_rst_timeout", 32'(timeout_err), 32'd0);
        tick();
        rst = 1'b0;
        req_valid = 4'b1111;
        @(negedge clk);
        check("t5_first_after_rst", 32'(req_ready), 32'h1);
        serve(64, 1'b1, 4'b0000, gid);
        check("t5_grant", 32'(gid), 32'd0);

        // enc_busy high in IDLE blocks every request; spurious done ignored
        req_valid = 4'b1111;
        enc_busy  = 1'b1;
        for (int k = 0; k < 5; k++) begin
            enc_done = (k == 2);
            @(negedge clk);
            check("t6_blocked", 32'(req_ready), 32'd0);
            tick();
        end
        enc_done = 1'b0;
        enc_busy = 1'b0;
        @(negedge clk);
        check("t6_release", 32'(req_ready), 32'h2);
        serve(64, 1'b1, 4'b0000, gid);
        check("t6_grant", 32'(gid), 32'd1);
        @(negedge clk);
        check("t6_count", 32'(frame_count), 32'd2);
        check("timeout_pulses", 32'(n_to), 32'd2);

        repeat (3) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/hamming_tx_scheduler.md
HAMMING_TX_SCHEDULER -- requirements
Module: hamming_tx_scheduler

Interface
REQ-001 Parameter N_REQ, default 4, number of requesters sharing one Hamming frame encoder; legal range 2..8.
REQ-002 Parameter TIMEOUT, default 256, maximum cycles from enc_start to enc_done before abort; minimum 4.
REQ-003 Port clk_in  input  1  sole clock; all logic on rising edge.
REQ-004 Port rst  input  1  reset, synchronous, active-high.
REQ-005 Port req_valid  input  N_REQ  per-requester 32-bit word pending.
REQ-006 Port req_data  input  N_REQ*32  requester i word in bits [32*i+31:32*i]; bit 31 transmitted first.
REQ-007 Port req_ready  output  N_REQ  per-requester accept; transfer when valid and ready are both high at a clock edge.
REQ-008 Port enc_data  output  32  registered word presented to encoder.
REQ-009 Port enc_start  output  1  one-cycle pulse: encoder loads enc_data and begins a 64-bit frame.
REQ-010 Port enc_busy  input  1  encoder serializing a frame.
REQ-011 Port enc_done  input  1  one-cycle pulse: last frame bit sent.
REQ-012 Port grant_id  output  clog2(N_REQ)  index of the requester owning the current frame.
REQ-013 Port busy  output  1  high whenever state is not IDLE.
REQ-014 Port timeout_err  output  1  one-cycle pulse on frame abort.
REQ-015 Port frame_count  output  16  frames completed since reset.

Function
REQ-016 States IDLE, LOAD, WAIT_BUSY, WAIT_DONE; exactly one active per cycle.
REQ-017 IDLE: when enc_busy low and any req_valid high, winner = first valid index searching upward (wrapping) from last_grant+1; req_ready high for winner only, combinationally, zero for all others.
REQ-018 IDLE with enc_busy high or no valid: all req_ready low, stay IDLE.
REQ-019 On transfer: enc_data <= winner word, grant_id <= winner, last_grant <= winner, next state LOAD.
REQ-020 LOAD: enc_start high for exactly one cycle (cycle after transfer); timeout counter cleared; next WAIT_BUSY.
REQ-021 WAIT_BUSY: enc_busy high -> WAIT_DONE; enc_done high (same or earlier than busy) -> IDLE as completion.
REQ-022 WAIT_DONE: enc_done high -> IDLE; frame_count increments by 1, wrapping 0xFFFF -> 0x0000.
REQ-023 Timeout counter increments each cycle in WAIT_BUSY/WAIT_DONE; at TIMEOUT-1 without enc_done: timeout_err pulses one cycle, state -> IDLE, frame_count unchanged; enc_done in that same cycle wins (completion, no error).
REQ-024 enc_data and grant_id hold stable from LOAD until next transfer.
REQ-025 Latency: transfer edge T -> enc_start high in cycle T+1; earliest next transfer one cycle after returning to IDLE.
REQ-026 Requester may drop req_valid without a transfer; no state change results.
REQ-027 Fairness: with all requesters continuously valid, grants rotate 0,1,...,N_REQ-1,0; no requester waits more than N_REQ-1 frames.
REQ-028 Spurious enc_done in IDLE or LOAD is ignored.

Reset
REQ-029 On rst: state IDLE, req_ready 0, enc_data 0, enc_start 0, grant_id 0, busy 0, timeout_err 0, frame_count 0, timeout counter 0, last_grant N_REQ-1 (requester 0 wins first).
REQ-030 rst mid-frame aborts immediately with no timeout_err and no count increment; rst overrides all other inputs.

Structure
REQ-031 Shared package hamming_pkg holds state enumeration, WORD_W=32, FRAME_W=64, FRAME_HEADER=8'b01111110.
REQ-032 One sub-module rr_arbiter (combinational round-robin pick: request vector, last_grant -> one-hot grant, index, any); all state in hamming_tx_scheduler.

Verification
REQ-033 Single requester: req_valid=0001, data 0xDEADBEEF -> req_ready[0] same cycle, enc_start next cycle, enc_data=0xDEADBEEF; enc_done after 64 cycles -> frame_count=1, busy low.
REQ-034 All four valid continuously for 8 frames -> grant_id sequence 0,1,2,3,0,1,2,3; frame_count=8.
REQ-035 Encoder never asserts enc_busy/enc_done, TIMEOUT=256 -> timeout_err pulse exactly 256 cycles after enc_start, frame_count unchanged, next request granted.
REQ-036 enc_done coincident with timeout expiry -> no timeout_err, frame_count increments.
REQ-037 rst asserted in WAIT_DONE -> next cycle all outputs at reset values, last_grant=3, requester 0 granted first afterwards.
REQ-038 enc_busy held high in IDLE with req_valid=1111 -> req_ready stays 0000 until enc_busy falls.
